seq_simd_alu: RTL and testbench
===============================

// Module: seq_simd_alu
// PURPOSE
//  Multi-cycle parametrised ALU for the Phase 2 datapath. Reuses one LANE_W-bit adder
//  slice serially across lanes, and one shifter stage bit-serially.
//  Supports:
//   - full-width saturating ADD/SUB
//   - per-lane saturating PADD
//   - lane-sum reduction RED
//   - SLL/SRA/ROR
//  Issued by the execute stage via start/done; stalls the pipeline while busy.
// PARAMETERS
//  DATA_W  16  operand/result width; must be a multiple of LANE_W
//  LANE_W  4   adder slice / PADD lane width; LANES = DATA_W/LANE_W
// PORTS
//  clk     in   1                  clock, all state on posedge
//  rst     in   1                  synchronous, active-high reset
//  start   in   1                  request; sampled only in IDLE
//  op      in   3                  000 ADD, 001 SUB, 010 PADD, 011 RED, 100 SLL, 101 SRA, 110 ROR, 111 rsvd
//  a       in   DATA_W             operand A (also shift source)
//  b       in   DATA_W             operand B
//  shamt   in   $clog2(DATA_W)     shift amount
//  busy    out  1                  high in every non-IDLE state
//  done    out  1                  one-cycle pulse; result/flags valid from here until next accepted start
//  result  out  DATA_W             registered result
//  flag_z  out  1                  result == 0
//  flag_v  out  1                  saturation/overflow occurred
//  flag_n  out  1                  result[DATA_W-1]
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, flag_z/v/n=0.
//   Applies in any state; an in-flight op is aborted and never produces done.
//  Accept: start=1 in IDLE latches a, b, op, shamt. Next state: ARITH (op 000-011) or SHIFT (op 100-110).
//   Shifts with shamt=0, and op 111, go straight to DONE.
//   start while busy (incl. DONE) is ignored; inputs are not re-sampled.
//  FSM: IDLE -> ARITH|SHIFT|DONE -> DONE -> IDLE.
//   DONE lasts exactly one cycle: done=1, outputs updated on entry.
//  ARITH: lane counter i = 0..LANES-1, one lane per cycle, LSB lane first.
//   - ADD/SUB: carry registered between lanes. SUB inverts B, cin=1 on lane 0.
//     After the last lane, on full-width signed overflow: result = 0x7FFF.. if a[MSB]=0, else 0x8000..; flag_v=1.
//   - PADD: no carry between lanes (cin=0 each lane). Each lane saturates to 0111../1000.. on its own.
//     flag_v = OR of lane overflows.
//   - RED: acc (DATA_W) += sext(a_lane_i) + sext(b_lane_i). Wrapping, no saturation; flag_v=0.
//   - Latency start->done = LANES+1 cycles.
//  SHIFT: one bit position per cycle, shamt cycles; latency = shamt+1.
//   - SLL: fill 0.
//   - SRA: fill with sign.
//   - ROR: bit 0 -> MSB.
//   - flag_v=0.
//  op 111: result=a, flag_v=0, latency 1.
//  Flags: computed from the final result, written in the same cycle as result.
// STRUCTURE
//  Package alu_pkg:
//   - alu_op_e enum (encodings above)
//   - alu_state_e {IDLE, ARITH, SHIFT, DONE}
//   - SAT_POS/SAT_NEG helper functions
//  Sub-module lane_addsub #(LANE_W): combinational.
//   - in: a, b, sub, cin, sat
//   - out: sum, cout, ovfl
//   - Instantiated once; the FSM muxes lane slices into it.
//  Top holds the FSM, lane/shift counter, operand, carry and accumulator registers.
// TESTING (DATA_W=16, LANE_W=4)
//  1. ADD a=7FFF b=0001 -> done exactly 5 cycles after start; result=7FFF, v=1, n=0, z=0.
//  2. SUB cases:
//     - a=8000 b=0001 -> result=8000, v=1, n=1
//     - a=0005 b=0003 -> result=0002, v=0
//     - a=0003 b=0003 -> result=0000, z=1
//  3. PADD a=7878 b=1111 -> result=7979, v=1; PADD a=1234 b=1111 -> result=2345, v=0.
//  4. RED a=1234 b=F0F0 -> result=0008, v=0, latency 5.
//  5. Shifts:
//     - SRA a=8000 shamt=3 -> F000, done 4 cycles after start
//     - ROR a=0001 shamt=1 -> 8000
//     - SLL a=ABCD shamt=0 -> ABCD, latency 1
//  6. Reset/ignore:
//     - rst asserted 2 cycles into ADD -> busy=0 next cycle, no done pulse, result=0
//     - start pulsed while busy -> ignored; first op's result unchanged

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential SIMD ALU.
//   alu_op_e    : operation encodings as seen on the op port
//   alu_state_e : controller states
//   alu_flags_t : registered status flags
//   sat_pos/sat_neg : signed saturation limits for a w-bit two's-complement value
package alu_pkg;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_PADD = 3'b010,
        OP_RED  = 3'b011,
        OP_SLL  = 3'b100,
        OP_SRA  = 3'b101,
        OP_ROR  = 3'b110,
        OP_RSVD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARITH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } alu_state_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } alu_flags_t;

    // Most positive w-bit signed value (0111..1), returned in the low w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int unsigned w);
        return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    endfunction

    // Most negative w-bit signed value (1000..0), returned in the low w bits.
    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int unsigned w);
        return SAT_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/lane_addsub.sv
// One LANE_W-bit add/subtract slice, purely combinational.
//   a, b  : lane operands
//   sub   : subtract (b is inverted; caller supplies cin=1 on the first lane)
//   cin   : carry in
//   sat   : clamp the sum to the signed lane range on overflow
//   sum   : lane result (raw or saturated)
//   cout  : carry out of the lane
//   ovfl  : signed overflow of this lane
module lane_addsub
    import alu_pkg::*;
#(
    parameter int unsigned LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sub,
    input  logic              cin,
    input  logic              sat,
    output logic [LANE_W-1:0] sum,
    output logic              cout,
    output logic              ovfl
);

    logic [LANE_W-1:0] b_eff;
    logic [LANE_W:0]   raw;

    always_comb begin
        b_eff = sub ? ~b : b;
        raw   = {1'b0, a} + {1'b0, b_eff} + (LANE_W + 1)'(cin);
        cout  = raw[LANE_W];
        // Signed overflow: operands agree in sign, sum disagrees.
        ovfl  = (a[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
        sum   = raw[LANE_W-1:0];
        if (sat && ovfl) begin
            sum = a[LANE_W-1] ? LANE_W'(sat_neg(LANE_W)) : LANE_W'(sat_pos(LANE_W));
        end
    end

endmodule

// File: rtl/seq_simd_alu.sv
// Multi-cycle ALU: one lane adder reused serially across lanes, one-bit shifter
// reused once per shift position.
//   clk, rst       : clock, synchronous active-high reset
//   start, op      : request (sampled only in IDLE) and operation
//   a, b, shamt    : operands and shift amount, latched on accept
//   busy           : high in every non-IDLE state
//   done           : one-cycle pulse when result/flags are updated
//   result, flag_z, flag_v, flag_n : registered result and status
module seq_simd_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LANE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                op,
    input  logic [DATA_W-1:0]         a,
    input  logic [DATA_W-1:0]         b,
    input  logic [$clog2(DATA_W)-1:0] shamt,
    output logic                      busy,
    output logic                      done,
    output logic [DATA_W-1:0]         result,
    output logic                      flag_z,
    output logic                      flag_v,
    output logic                      flag_n
);

    localparam int unsigned LANES = DATA_W / LANE_W;
    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned EXT_W = DATA_W - LANE_W;

    alu_state_e  state_q, state_d;
    alu_op_e     op_q, op_d, op_in;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              vacc_q, vacc_d;
    logic [DATA_W-1:0] result_q, result_d;
    alu_flags_t        flags_q, flags_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [LANE_W-1:0] lane_sum;
    logic              lane_cout, lane_ovfl;
    logic              lane_sub, lane_cin, lane_sat;

    logic [DATA_W-1:0] lane_packed_c;
    logic [DATA_W-1:0] red_next_c;
    logic [DATA_W-1:0] shifted_c;
    logic              last_lane_c;
    logic              last_shift_c;
    logic              write_res_c;
    logic [DATA_W-1:0] fin_res_c;
    logic              fin_v_c;

    assign op_in = alu_op_e'(op);

    // Lane slice: operands are shifted right each cycle, so lane i is always the low lane.
    always_comb begin
        lane_sub = (op_q == OP_SUB);
        lane_sat = (op_q == OP_PADD);
        lane_cin = (op_q == OP_PADD) ? 1'b0 : carry_q;
    end

    lane_addsub #(.LANE_W(LANE_W)) u_lane (
        .a    (a_q[LANE_W-1:0]),
        .b    (b_q[LANE_W-1:0]),
        .sub  (lane_sub),
        .cin  (lane_cin),
        .sat  (lane_sat),
        .sum  (lane_sum),
        .cout (lane_cout),
        .ovfl (lane_ovfl)
    );

    // Datapath helpers: lane results enter at the top so lane 0 ends at the bottom.
    always_comb begin
        lane_packed_c = {lane_sum, work_q[DATA_W-1:LANE_W]};
        red_next_c    = work_q
                      + {{EXT_W{a_q[LANE_W-1]}}, a_q[LANE_W-1:0]}
                      + {{EXT_W{b_q[LANE_W-1]}}, b_q[LANE_W-1:0]};
        case (op_q)
            OP_SLL:  shifted_c = {work_q[DATA_W-2:0], 1'b0};
            OP_SRA:  shifted_c = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
            OP_ROR:  shifted_c = {work_q[0], work_q[DATA_W-1:1]};
            default: shifted_c = work_q;
        endcase
        last_lane_c  = (cnt_q == CNT_W'(LANES - 1));
        last_shift_c = (cnt_q == CNT_W'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op_in == OP_RSVD) begin
                        state_d = DONE;
                    end else if (!op[2]) begin
                        state_d = ARITH;
                    end else if (shamt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            ARITH:   if (last_lane_c)  state_d = DONE;
            SHIFT:   if (last_shift_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        vacc_d      = vacc_q;
        write_res_c = 1'b0;
        fin_res_c   = work_q;
        fin_v_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_in;
                    a_d     = a;
                    b_d     = b;
                    carry_d = (op_in == OP_SUB);
                    vacc_d  = 1'b0;
                    cnt_d   = op[2] ? shamt : '0;
                    work_d  = op[2] ? a : '0;
                    // Zero-length shifts and the reserved op complete immediately with a.
                    if (op_in == OP_RSVD || (op[2] && shamt == '0)) begin
                        write_res_c = 1'b1;
                        fin_res_c   = a;
                    end
                end
            end
            ARITH: begin
                a_d     = a_q >> LANE_W;
                b_d     = b_q >> LANE_W;
                cnt_d   = cnt_q + CNT_W'(1);
                carry_d = lane_cout;
                if (op_q == OP_RED) begin
                    work_d = red_next_c;
                end else begin
                    work_d = lane_packed_c;
                end
                if (op_q == OP_PADD) begin
                    vacc_d = vacc_q | lane_ovfl;
                end
                if (last_lane_c) begin
                    write_res_c = 1'b1;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            // Last-lane overflow with the carry chain is full-width overflow;
                            // a_q's low lane now holds the original top lane of a.
                            fin_v_c = lane_ovfl;
                            if (lane_ovfl) begin
                                fin_res_c = a_q[LANE_W-1] ? DATA_W'(sat_neg(DATA_W))
                                                          : DATA_W'(sat_pos(DATA_W));
                            end else begin
                                fin_res_c = lane_packed_c;
                            end
                        end
                        OP_PADD: begin
                            fin_res_c = lane_packed_c;
                            fin_v_c   = vacc_q | lane_ovfl;
                        end
                        default: begin
                            fin_res_c = red_next_c;
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = shifted_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_shift_c) begin
                    write_res_c = 1'b1;
                    fin_res_c   = shifted_c;
                end
            end
            default: ;
        endcase

        result_d = result_q;
        flags_d  = flags_q;
        if (write_res_c) begin
            result_d  = fin_res_c;
            flags_d.z = (fin_res_c == '0);
            flags_d.v = fin_v_c;
            flags_d.n = fin_res_c[DATA_W-1];
        end
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            vacc_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            vacc_q   <= vacc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flag_z = flags_q.z;
    assign flag_v = flags_q.v;
    assign flag_n = flags_q.n;

endmodule

// File: tb/tb_seq_simd_alu.sv
// Self-checking bench for seq_simd_alu (DATA_W=16, LANE_W=4).
module tb_seq_simd_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  shamt;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        v;
        logic        n;
        int          lat;
    } exp_t;

    exp_t sb[$];

    seq_simd_alu #(.DATA_W(16), .LANE_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_z (flag_z),
        .flag_v (flag_v),
        .flag_n (flag_n)
    );

    always #5 clk = ~clk;

    // Reference model: returns {v, result}.
    function automatic logic [16:0] model(input logic [2:0] o, input logic [15:0] x,
                                          input logic [15:0] y, input logic [3:0] sh);
        int          s;
        int          l;
        int          acc;
        logic [15:0] r;
        logic        v;
        logic [3:0]  xl;
        logic [3:0]  yl;
        v = 1'b0;
        r = x;
        case (o)
            3'd0, 3'd1: begin
                s = (o == 3'd0) ? int'($signed(x)) + int'($signed(y))
                                : int'($signed(x)) - int'($signed(y));
                if (s > 32767) begin
                    r = 16'h7FFF; v = 1'b1;
                end else if (s < -32768) begin
                    r = 16'h8000; v = 1'b1;
                end else begin
                    r = 16'(s);
                end
            end
            3'd2: begin
                for (int i = 0; i < 4; i++) begin
                    xl = x[i*4 +: 4];
                    yl = y[i*4 +: 4];
                    l = int'($signed(xl)) + int'($signed(yl));
                    if (l > 7) begin
                        l = 7; v = 1'b1;
                    end else if (l < -8) begin
                        l = -8; v = 1'b1;
                    end
                    r[i*4 +: 4] = 4'(l);
                end
            end
            3'd3: begin
                acc = 0;
                for (int i = 0; i < 4; i++) begin
                    xl = x[i*4 +: 4];
                    yl = y[i*4 +: 4];
                    acc = acc + int'($signed(xl)) + int'($signed(yl));
                end
                r = 16'(acc);
            end
            3'd4: r = x << sh;
            3'd5: r = 16'($signed(x) >>> sh);
            3'd6: r = (sh == 4'd0) ? x : ((x >> sh) | (x << (5'd16 - {1'b0, sh})));
            default: r = x;
        endcase
        return {v, r};
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [3:0] sh);
        if (o <= 3'd3) return 5;
        if (o == 3'd7 || sh == 4'd0) return 1;
        return int'(sh) + 1;
    endfunction

    // Push the expectation, issue the op, wait (bounded) for done, pop and compare.
    task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] aa,
                          input logic [15:0] bb, input logic [3:0] sh,
                          input logic [15:0] er, input logic ev, input int el);
        exp_t e;
        int   lat;
        e.res = er; e.z = (er == 16'h0); e.v = ev; e.n = er[15]; e.lat = el;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb; shamt = sh;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                // Scramble inputs: the DUT must work from its latched copies.
                a = 16'($urandom); b = 16'($urandom); shamt = 4'($urandom); op = 3'($urandom);
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: got %b want 1", name, busy);
                end
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        e = sb.pop_front();
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
        end else begin
            checks++;
            if (lat != e.lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
            end
            checks++;
            if ({result, flag_z, flag_v, flag_n} !== {e.res, e.z, e.v, e.n}) begin
                errors++;
                $display("FAIL %s result: got %h z%b v%b n%b want %h z%b v%b n%b",
                         name, result, flag_z, flag_v, flag_n, e.res, e.z, e.v, e.n);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s pulse: done %b busy %b after done, want 0 0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; shamt = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, result, flag_z, flag_v, flag_n} !== 21'h0) begin
            errors++;
            $display("FAIL reset: got busy%b done%b res %h z%b v%b n%b want all 0",
                     busy, done, result, flag_z, flag_v, flag_n);
        end
    endtask

    task automatic test_add();
        run_op("add_sat", 3'd0, 16'h7FFF, 16'h0001, 4'd0, 16'h7FFF, 1'b1, 5);
        run_op("add_plain", 3'd0, 16'h1234, 16'h0F0F, 4'd0, 16'h2143, 1'b0, 5);
    endtask

    task automatic test_sub();
        run_op("sub_sat", 3'd1, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b1, 5);
        run_op("sub_pos", 3'd1, 16'h0005, 16'h0003, 4'd0, 16'h0002, 1'b0, 5);
        run_op("sub_zero", 3'd1, 16'h0003, 16'h0003, 4'd0, 16'h0000, 1'b0, 5);
        run_op("sub_neg", 3'd1, 16'h0003, 16'h0005, 4'd0, 16'hFFFE, 1'b0, 5);
    endtask

    task automatic test_padd();
        run_op("padd_sat", 3'd2, 16'h7878, 16'h1111, 4'd0, 16'h7979, 1'b1, 5);
        run_op("padd_plain", 3'd2, 16'h1234, 16'h1111, 4'd0, 16'h2345, 1'b0, 5);
    endtask

    task automatic test_red();
        run_op("red", 3'd3, 16'h1234, 16'hF0F0, 4'd0, 16'h0008, 1'b0, 5);
        run_op("red_neg", 3'd3, 16'h8888, 16'h8888, 4'd0, 16'hFFC0, 1'b0, 5);
    endtask

    task automatic test_shift();
        run_op("sra3", 3'd5, 16'h8000, 16'h0000, 4'd3, 16'hF000, 1'b0, 4);
        run_op("ror1", 3'd6, 16'h0001, 16'h0000, 4'd1, 16'h8000, 1'b0, 2);
        run_op("sll0", 3'd4, 16'hABCD, 16'h0000, 4'd0, 16'hABCD, 1'b0, 1);
        run_op("sll15", 3'd4, 16'h0003, 16'h0000, 4'd15, 16'h8000, 1'b0, 16);
        run_op("rsvd", 3'd7, 16'h0000, 16'h1234, 4'd5, 16'h0000, 1'b0, 1);
    endtask

    task automatic test_abort();
        int seen;
        // Leave a non-zero result behind so the reset clear is observable.
        run_op("pre_abort", 3'd0, 16'h0100, 16'h0001, 4'd0, 16'h0101, 1'b0, 5);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 16'h7FFF; b = 16'h0001;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 16'h0) begin
            errors++;
            $display("FAIL abort_state: busy%b done%b res %h want 0 0 0000", busy, done, result);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d done pulses want 0", seen);
        end
    endtask

    task automatic test_ignore_start();
        int seen;
        exp_t e;
        int   lat;
        e.res = 16'h0008; e.z = 1'b0; e.v = 1'b0; e.n = 1'b0; e.lat = 5;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 16'h0005; b = 16'h0003; shamt = '0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 2) begin
                start = 1'b1; op = 3'd1; a = 16'hFFFF; b = 16'h0001;
            end
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        // Also request during the DONE cycle; must be dropped too.
        start = 1'b1; op = 3'd7; a = 16'hDEAD;
        e = sb.pop_front();
        checks++;
        if (lat != e.lat || result !== e.res || flag_v !== e.v || flag_z !== e.z) begin
            errors++;
            $display("FAIL ignore_first: lat %0d res %h v%b z%b want lat %0d res %h v%b z%b",
                     lat, result, flag_v, flag_z, e.lat, e.res, e.v, e.z);
        end
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || result !== 16'h0008) begin
            errors++;
            $display("FAIL ignore_later: %0d busy/done cycles res %h want 0 cycles res 0008",
                     seen, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra;
        logic [15:0] rb;
        logic [2:0]  ro;
        logic [3:0]  rs;
        logic [16:0] m;
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = 3'($urandom_range(0, 7));
            rs = 4'($urandom);
            m  = model(ro, ra, rb, rs);
            run_op("rand", ro, ra, rb, rs, m[15:0], m[16], model_lat(ro, rs));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_padd();
        test_red();
        test_shift();
        test_abort();
        test_ignore_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
